// File: rtl/mac_lane_array.sv
// Row of weight-stationary MAC lanes. Each lane multiplies an unsigned activation
// mantissa by a signed stationary weight and accumulates into a saturating
// accumulator. Activations are forwarded one cycle to the next column. The shadow
// weights form the load chain to the next row.
module mac_lane_array #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned MANT_W   = 7,
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned ACC_W    = 48
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LANES*MANT_W-1:0]     act_i,
    input  logic                        act_valid_i,
    input  logic                        acc_clr_i,
    input  logic [LANES-1:0]            lane_en_i,
    output logic [LANES*MANT_W-1:0]     act_o,
    output logic                        act_valid_o,
    output logic [LANES*ACC_W-1:0]      acc_o,
    output logic                        acc_valid_o,
    output logic [LANES-1:0]            sat_o,
    input  logic                        prepare_weight,
    input  logic                        set_weight_i,
    input  logic [LANES*WEIGHT_W-1:0]   wload_i,
    output logic [LANES*WEIGHT_W-1:0]   wload_o
);
    localparam int unsigned PROD_W = MANT_W + WEIGHT_W + 1;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [LANES*MANT_W-1:0]    act_q;
    logic                       act_valid_q;
    logic signed [WEIGHT_W-1:0] w_shadow_q [LANES];
    logic signed [WEIGHT_W-1:0] w_active_q [LANES];
    logic signed [PROD_W-1:0]   prod_d [LANES];
    logic signed [PROD_W-1:0]   prod_q [LANES];
    logic                       s1_valid_q;
    logic                       s1_clr_q;
    logic [LANES-1:0]           s1_en_q;
    logic signed [SUM_W-1:0]    sum [LANES];
    logic signed [ACC_W-1:0]    acc_d [LANES];
    logic signed [ACC_W-1:0]    acc_q [LANES];
    logic [LANES-1:0]           sat_d;
    logic [LANES-1:0]           sat_q;
    logic                       acc_valid_q;

    // Plain one-cycle forwarding of activations to the next column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q       <= '0;
            act_valid_q <= 1'b0;
        end else begin
            act_q       <= act_i;
            act_valid_q <= act_valid_i;
        end
    end

    // Shadow/active weight pair; commit takes the shadow value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                w_shadow_q[k] <= '0;
                w_active_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (prepare_weight) w_shadow_q[k] <= wload_i[k*WEIGHT_W +: WEIGHT_W];
                if (set_weight_i)   w_active_q[k] <= w_shadow_q[k];
            end
        end
    end

    // Stage 1 products: zero-extended activation times sign-extended active weight.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod_d[k] = $signed(PROD_W'({1'b0, act_i[k*MANT_W +: MANT_W]}))
                      * $signed(PROD_W'(w_active_q[k]));
        end
    end

    // Stage 1 register: products plus the beat's valid, clear and lane mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
            s1_valid_q <= 1'b0;
            s1_clr_q   <= 1'b0;
            s1_en_q    <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
            s1_valid_q <= act_valid_i;
            s1_clr_q   <= act_valid_i & acc_clr_i;
            s1_en_q    <= lane_en_i;
        end
    end

    // Stage 2 accumulate with one guard bit; clamp on overflow and set sticky flag.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            acc_d[k] = acc_q[k];
            sat_d[k] = sat_q[k];
            if (s1_clr_q) sum[k] = SUM_W'(prod_q[k]);
            else          sum[k] = SUM_W'(acc_q[k]) + SUM_W'(prod_q[k]);
            if (s1_valid_q && s1_en_q[k]) begin
                if (sum[k][SUM_W-1] != sum[k][SUM_W-2]) begin
                    acc_d[k] = sum[k][SUM_W-1] ? ACC_MIN : ACC_MAX;
                    sat_d[k] = 1'b1;
                end else begin
                    acc_d[k] = sum[k][ACC_W-1:0];
                    // Only a clean clear beat may drop the sticky flag.
                    if (s1_clr_q) sat_d[k] = 1'b0;
                end
            end
        end
    end

    // Stage 2 register: accumulators, sticky flags and the result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
            sat_q       <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < LANES; k++) acc_q[k] <= acc_d[k];
            sat_q       <= sat_d;
            acc_valid_q <= s1_valid_q;
        end
    end

    // Pack per-lane state onto the flat output buses.
    always_comb begin
        acc_o   = '0;
        wload_o = '0;
        for (int k = 0; k < LANES; k++) begin
            acc_o[k*ACC_W +: ACC_W]         = acc_q[k];
            wload_o[k*WEIGHT_W +: WEIGHT_W] = w_shadow_q[k];
        end
    end

    assign act_o       = act_q;
    assign act_valid_o = act_valid_q;
    assign acc_valid_o = acc_valid_q;
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_mac_lane_array.sv
// Bench for mac_lane_array: integer model of the lane arithmetic checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_mac_lane_array;
    localparam int LANES    = 4;
    localparam int MANT_W   = 7;
    localparam int WEIGHT_W = 8;
    localparam int ACC_W    = 16;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [LANES*MANT_W-1:0]   act_i;
    logic                      act_valid_i;
    logic                      acc_clr_i;
    logic [LANES-1:0]          lane_en_i;
    logic [LANES*MANT_W-1:0]   act_o;
    logic                      act_valid_o;
    logic [LANES*ACC_W-1:0]    acc_o;
    logic                      acc_valid_o;
    logic [LANES-1:0]          sat_o;
    logic                      prepare_weight;
    logic                      set_weight_i;
    logic [LANES*WEIGHT_W-1:0] wload_i;
    logic [LANES*WEIGHT_W-1:0] wload_o;

    mac_lane_array #(
        .LANES   (LANES),
        .MANT_W  (MANT_W),
        .WEIGHT_W(WEIGHT_W),
        .ACC_W   (ACC_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .act_i         (act_i),
        .act_valid_i   (act_valid_i),
        .acc_clr_i     (acc_clr_i),
        .lane_en_i     (lane_en_i),
        .act_o         (act_o),
        .act_valid_o   (act_valid_o),
        .acc_o         (acc_o),
        .acc_valid_o   (acc_valid_o),
        .sat_o         (sat_o),
        .prepare_weight(prepare_weight),
        .set_weight_i  (set_weight_i),
        .wload_i       (wload_i),
        .wload_o       (wload_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state: plain integers per lane.
    longint m_shadow [LANES];
    longint m_active [LANES];
    longint m_acc    [LANES];
    bit     m_sat    [LANES];
    // Beat accepted at the previous edge, waiting to be accumulated.
    bit               p_valid;
    bit               p_clr;
    bit [LANES-1:0]   p_en;
    longint           p_prod [LANES];
    // Expected forwarded values and result strobe.
    logic [LANES*MANT_W-1:0] e_act;
    bit                      e_act_v;
    bit                      e_acc_v;

    task automatic cmp(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic longint lane_acc(input int k);
        return longint'($signed(acc_o[k*ACC_W +: ACC_W]));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) begin
            m_shadow[k] = 0;
            m_active[k] = 0;
            m_acc[k]    = 0;
            m_sat[k]    = 1'b0;
            p_prod[k]   = 0;
        end
        p_valid = 1'b0;
        p_clr   = 1'b0;
        p_en    = '0;
        e_act   = '0;
        e_act_v = 1'b0;
        e_acc_v = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        longint s;
        if (!rst_n) return;
        e_acc_v = p_valid;
        if (p_valid) begin
            for (int k = 0; k < LANES; k++) begin
                if (p_en[k]) begin
                    s = (p_clr ? 0 : m_acc[k]) + p_prod[k];
                    if (s > ACC_MAX) begin
                        m_acc[k] = ACC_MAX;
                        m_sat[k] = 1'b1;
                    end else if (s < ACC_MIN) begin
                        m_acc[k] = ACC_MIN;
                        m_sat[k] = 1'b1;
                    end else begin
                        m_acc[k] = s;
                        if (p_clr) m_sat[k] = 1'b0;
                    end
                end
            end
        end
        p_valid = act_valid_i;
        p_clr   = act_valid_i & acc_clr_i;
        p_en    = lane_en_i;
        for (int k = 0; k < LANES; k++) begin
            p_prod[k] = longint'(act_i[k*MANT_W +: MANT_W]) * m_active[k];
            if (set_weight_i)   m_active[k] = m_shadow[k];
            if (prepare_weight) m_shadow[k] = longint'($signed(wload_i[k*WEIGHT_W +: WEIGHT_W]));
        end
        e_act   = act_i;
        e_act_v = act_valid_i;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [LANES*WEIGHT_W-1:0] ew;
            logic [LANES-1:0]          es;
            for (int k = 0; k < LANES; k++) begin
                ew[k*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(m_shadow[k]);
                es[k] = m_sat[k];
                cmp($sformatf("acc_o[%0d]", k), lane_acc(k), m_acc[k]);
            end
            cmp("act_o", longint'(act_o), longint'(e_act));
            cmp("act_valid_o", longint'(act_valid_o), longint'(e_act_v));
            cmp("acc_valid_o", longint'(acc_valid_o), longint'(e_acc_v));
            cmp("sat_o", longint'(sat_o), longint'(es));
            cmp("wload_o", longint'(wload_o), longint'(ew));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        act_valid_i = 1'b0;
        acc_clr_i   = 1'b0;
        cyc();
    endtask

    task automatic beat(input logic [MANT_W-1:0] a, input bit clr, input logic [LANES-1:0] en);
        act_i       = {LANES{a}};
        act_valid_i = 1'b1;
        acc_clr_i   = clr;
        lane_en_i   = en;
        cyc();
        act_valid_i = 1'b0;
        acc_clr_i   = 1'b0;
    endtask

    task automatic load_w(input logic [WEIGHT_W-1:0] w);
        wload_i        = {LANES{w}};
        prepare_weight = 1'b1;
        cyc();
        prepare_weight = 1'b0;
        set_weight_i   = 1'b1;
        cyc();
        set_weight_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1; act_i = '0; act_valid_i = 1'b0; acc_clr_i = 1'b0; lane_en_i = '0;
        prepare_weight = 1'b0; set_weight_i = 1'b0; wload_i = '0;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp("reset act_o", longint'(act_o), 0);
        cmp("reset acc_o", longint'(acc_o), 0);
        cmp("reset sat_o", longint'(sat_o), 0);
        cmp("reset wload_o", longint'(wload_o), 0);
        cmp("reset acc_valid_o", longint'(acc_valid_o), 0);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // T1: weight load chain and commit.
        prepare_weight = 1'b1;
        wload_i = 32'h44332211; cyc(); cmp("T1 wload_o #1", longint'(wload_o), 64'h44332211);
        wload_i = 32'h88776655; cyc(); cmp("T1 wload_o #2", longint'(wload_o), 64'h88776655);
        wload_i = 32'h44332211; cyc(); cmp("T1 wload_o #3", longint'(wload_o), 64'h44332211);
        prepare_weight = 1'b0;
        set_weight_i = 1'b1; cyc(); set_weight_i = 1'b0;
        beat(7'd1, 1'b1, 4'hF); idle();
        cmp("T1 lane0 weight", lane_acc(0), 17);
        cmp("T1 lane3 weight", lane_acc(3), 68);

        // T2: w=-3, act 5 with clear then act 7.
        load_w(8'hFD);
        beat(7'd5, 1'b1, 4'hF);
        beat(7'd7, 1'b0, 4'hF);
        cmp("T2 acc -15", lane_acc(0), -15);
        cmp("T2 valid 1", longint'(acc_valid_o), 1);
        idle();
        cmp("T2 acc -36", lane_acc(0), -36);
        cmp("T2 valid 2", longint'(acc_valid_o), 1);
        idle();
        cmp("T2 valid drops", longint'(acc_valid_o), 0);

        // T3: commit and beat in the same cycle use the old weight.
        load_w(8'd2);
        wload_i = {LANES{8'd4}}; prepare_weight = 1'b1; cyc(); prepare_weight = 1'b0;
        set_weight_i = 1'b1;
        beat(7'd1, 1'b1, 4'hF);
        set_weight_i = 1'b0;
        beat(7'd1, 1'b0, 4'hF);
        cmp("T3 old weight", lane_acc(0), 2);
        idle();
        cmp("T3 new weight", lane_acc(0), 6);

        // T4: lane mask on a clear beat.
        load_w(8'd1);
        beat(7'd1, 1'b1, 4'b0101); idle();
        cmp("T4 lane0", lane_acc(0), 1);
        cmp("T4 lane1 hold", lane_acc(1), 6);
        cmp("T4 lane2", lane_acc(2), 1);
        cmp("T4 lane3 hold", lane_acc(3), 6);

        // T5: positive saturation, masked clear keeps flag, clean clear drops it.
        load_w(8'h7F);
        beat(7'd127, 1'b1, 4'hF);
        beat(7'd127, 1'b0, 4'hF);
        beat(7'd127, 1'b0, 4'hF);
        cmp("T5 acc 32258", lane_acc(0), 32258);
        cmp("T5 sat 0", longint'(sat_o), 0);
        beat(7'd127, 1'b0, 4'hF);
        cmp("T5 clamp", lane_acc(0), 32767);
        cmp("T5 sat set", longint'(sat_o), 15);
        idle();
        cmp("T5 clamp hold", lane_acc(0), 32767);
        cmp("T5 sat sticky", longint'(sat_o), 15);
        beat(7'd0, 1'b1, 4'b1101); idle();
        cmp("T5 clr acc", lane_acc(0), 0);
        cmp("T5 masked lane", lane_acc(1), 32767);
        cmp("T5 sat after clr", longint'(sat_o), 2);
        // Negative clamp.
        load_w(8'h80);
        beat(7'd127, 1'b1, 4'hF);
        beat(7'd127, 1'b0, 4'hF);
        beat(7'd127, 1'b0, 4'hF);
        idle();
        cmp("T5 neg clamp", lane_acc(0), -32768);
        cmp("T5 neg sat", longint'(sat_o), 15);

        // T6: reset with beats in flight.
        beat(7'd3, 1'b1, 4'hF);
        act_i = {LANES{7'd5}}; act_valid_i = 1'b1; cyc();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        cmp("T6 act_o", longint'(act_o), 0);
        cmp("T6 act_valid_o", longint'(act_valid_o), 0);
        cmp("T6 acc_o", longint'(acc_o), 0);
        cmp("T6 acc_valid_o", longint'(acc_valid_o), 0);
        cmp("T6 sat_o", longint'(sat_o), 0);
        cmp("T6 wload_o", longint'(wload_o), 0);
        act_valid_i = 1'b0;
        cyc(); cyc();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            cmp("T6 no pulse", longint'(acc_valid_o), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
